// File: rtl/alu_writeback.sv
// ALU writeback stage: queues result pairs and serialises them onto one register-file write port.
// Optional `ALU_WB_BYPASS_EN` adds a combinational lookup of not-yet-retired writes (q_addr/q_hit/q_data).
module alu_writeback #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_y1,
  input  logic [WIDTH-1:0]         in_y2,
  input  logic [AW-1:0]            in_rd1,
  input  logic [AW-1:0]            in_rd2,
  input  logic [1:0]               in_wmask,
  input  logic                     wr_stall,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [WIDTH-1:0]         wr_data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
`ifdef ALU_WB_BYPASS_EN
  ,
  input  logic [AW-1:0]            q_addr,
  output logic                     q_hit,
  output logic [WIDTH-1:0]         q_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] y1_q   [DEPTH];
  logic [WIDTH-1:0] y1_d   [DEPTH];
  logic [WIDTH-1:0] y2_q   [DEPTH];
  logic [WIDTH-1:0] y2_d   [DEPTH];
  logic [AW-1:0]    rd1_q  [DEPTH];
  logic [AW-1:0]    rd1_d  [DEPTH];
  logic [AW-1:0]    rd2_q  [DEPTH];
  logic [AW-1:0]    rd2_d  [DEPTH];
  logic [1:0]       mask_q [DEPTH];
  logic [1:0]       mask_d [DEPTH];

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             phase_q, phase_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;

  logic             push, pop, load_slot, retire;
  logic [1:0]       head_mask;

  assign in_ready = (count_q < DEPTH_C);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign count    = count_q;
  assign busy     = (count_q != '0) || wr_en_q;

  always_comb begin
    y1_d      = y1_q;
    y2_d      = y2_q;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    mask_d    = mask_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    phase_d   = phase_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pop       = 1'b0;
    push      = in_valid && in_ready;
    retire    = wr_en_q && !wr_stall;
    load_slot = !wr_en_q || !wr_stall;
    head_mask = mask_q[rd_ptr_q];

    // A mask-00 entry still uses up a load slot, so the port goes idle for that cycle.
    if (load_slot && (count_q != '0)) begin
      case (head_mask)
        2'b11: begin
          wr_en_d = 1'b1;
          if (!phase_q) begin
            wr_addr_d = rd1_q[rd_ptr_q];
            wr_data_d = y1_q[rd_ptr_q];
            phase_d   = 1'b1;
          end else begin
            wr_addr_d = rd2_q[rd_ptr_q];
            wr_data_d = y2_q[rd_ptr_q];
            phase_d   = 1'b0;
            pop       = 1'b1;
          end
        end
        2'b01: begin
          wr_en_d   = 1'b1;
          wr_addr_d = rd1_q[rd_ptr_q];
          wr_data_d = y1_q[rd_ptr_q];
          pop       = 1'b1;
        end
        2'b10: begin
          wr_en_d   = 1'b1;
          wr_addr_d = rd2_q[rd_ptr_q];
          wr_data_d = y2_q[rd_ptr_q];
          pop       = 1'b1;
        end
        default: begin
          wr_en_d = 1'b0;
          pop     = 1'b1;
        end
      endcase
    end else if (retire) begin
      wr_en_d = 1'b0;
    end

    if (push) begin
      y1_d[wr_ptr_q]   = in_y1;
      y2_d[wr_ptr_q]   = in_y2;
      rd1_d[wr_ptr_q]  = in_rd1;
      rd2_d[wr_ptr_q]  = in_rd2;
      mask_d[wr_ptr_q] = in_wmask;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1_q      <= '{default: '0};
      y2_q      <= '{default: '0};
      rd1_q     <= '{default: '0};
      rd2_q     <= '{default: '0};
      mask_q    <= '{default: '0};
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      phase_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      mask_q    <= mask_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      phase_q   <= phase_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef ALU_WB_BYPASS_EN
  logic [PW-1:0] q_idx;

  // Scan oldest to youngest so the last match (youngest write) wins.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    q_idx  = rd_ptr_q;
    if (q_addr != '0) begin
      if (wr_en_q && (wr_addr_q == q_addr)) begin
        q_hit  = 1'b1;
        q_data = wr_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        q_idx = rd_ptr_q + PW'(i);
        if (CW'(i) < count_q) begin
          if (mask_q[q_idx][0] && !((i == 0) && phase_q) && (rd1_q[q_idx] == q_addr)) begin
            q_hit  = 1'b1;
            q_data = y1_q[q_idx];
          end
          if (mask_q[q_idx][1] && (rd2_q[q_idx] == q_addr)) begin
            q_hit  = 1'b1;
            q_data = y2_q[q_idx];
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: queue-of-writes reference model, per-cycle compare, directed and random stimulus.
module tb_alu_writeback;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, wr_stall = 1'b0;
  logic [31:0] in_y1 = '0, in_y2 = '0;
  logic [4:0]  in_rd1 = '0, in_rd2 = '0;
  logic [1:0]  in_wmask = '0;
  logic        in_ready, wr_en, busy;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  count;
`ifdef ALU_WB_BYPASS_EN
  logic [4:0]  q_addr = '0;
  logic        q_hit;
  logic [31:0] q_data;
`endif

  always #5 clk = ~clk;

  alu_writeback #(.WIDTH(32), .AW(5), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_y1(in_y1), .in_y2(in_y2), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_wmask(in_wmask),
    .wr_stall(wr_stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .count(count)
`ifdef ALU_WB_BYPASS_EN
    , .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data)
`endif
  );

  // Model: every accepted pair becomes its list of pending write slots (a null slot for mask 00).
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          nul;
    bit          last;
  } slot_t;

  slot_t       slots[$];
  slot_t       ms;
  bit          m_v = 0;
  logic [4:0]  m_a = '0;
  logic [31:0] m_d = '0;
  bit          m_acc;
  int          n_vec = 0, n_err = 0;
  logic [4:0]  obs_a[$];

  function automatic int m_pairs();
    int n = 0;
    foreach (slots[i]) if (slots[i].last) n++;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots.delete();
      m_v = 0; m_a = '0; m_d = '0;
    end else begin
      m_acc = in_valid && (m_pairs() < 2);
      if ((!m_v || !wr_stall) && slots.size() > 0) begin
        ms = slots.pop_front();
        if (ms.nul) m_v = 0;
        else begin m_v = 1; m_a = ms.a; m_d = ms.d; end
      end else if (m_v && !wr_stall) begin
        m_v = 0;
      end
      if (m_acc) begin
        case (in_wmask)
          2'b00: slots.push_back('{a: 5'd0,   d: 32'd0, nul: 1, last: 1});
          2'b01: slots.push_back('{a: in_rd1, d: in_y1, nul: 0, last: 1});
          2'b10: slots.push_back('{a: in_rd2, d: in_y2, nul: 0, last: 1});
          default: begin
            slots.push_back('{a: in_rd1, d: in_y1, nul: 0, last: 0});
            slots.push_back('{a: in_rd2, d: in_y2, nul: 0, last: 1});
          end
        endcase
      end
    end
  end

`ifdef ALU_WB_BYPASS_EN
  function automatic void m_byp(input logic [4:0] qa, output bit h, output logic [31:0] d);
    h = 0; d = '0;
    if (qa != 5'd0) begin
      if (m_v && m_a == qa) begin h = 1; d = m_d; end
      foreach (slots[i]) if (!slots[i].nul && slots[i].a == qa) begin h = 1; d = slots[i].d; end
    end
  endfunction
  bit          e_hit;
  logic [31:0] e_qd;
`endif

  always @(negedge clk) begin
    chk("wr_en", wr_en, m_v);
    chk("wr_addr", wr_addr, m_a);
    chk("wr_data", wr_data, m_d);
    chk("count", count, m_pairs());
    chk("in_ready", in_ready, m_pairs() < 2);
    chk("busy", busy, (m_pairs() != 0) || m_v);
`ifdef ALU_WB_BYPASS_EN
    m_byp(q_addr, e_hit, e_qd);
    chk("q_hit", q_hit, e_hit);
    if (e_hit) chk("q_data", q_data, e_qd);
`endif
    if (rst_n && wr_en && !wr_stall) obs_a.push_back(wr_addr);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [4:0] r1, input logic [4:0] r2, input logic [1:0] m,
                      input logic [31:0] a, input logic [31:0] b);
    bit r;
    int k = 0;
    in_valid = 1; in_rd1 = r1; in_rd2 = r2; in_wmask = m; in_y1 = a; in_y2 = b;
    do begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1; k++;
    end while (!r && k < 50);
    in_valid = 0;
    if (!r) begin
      n_vec++; n_err++;
      $display("FAIL push_timeout: in_ready stayed 0, want 1");
    end
  endtask

  logic [4:0]  exp_a[4];
  logic [4:0]  sa;
  logic [31:0] sd;

  initial begin
    #3;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // single pair, first write one edge after acceptance
    push(5'd3, 5'd4, 2'b11, 32'h11111111, 32'h22222222);
    cyc();
    chk("sp_en0", wr_en, 1); chk("sp_a0", wr_addr, 3); chk("sp_d0", wr_data, 32'h11111111);
    cyc();
    chk("sp_en1", wr_en, 1); chk("sp_a1", wr_addr, 4); chk("sp_d1", wr_data, 32'h22222222);
    cyc();
    chk("sp_en2", wr_en, 0);
    repeat (3) cyc();

    // mask coverage 01,10,00,11
    obs_a.delete();
    push(5'd1, 5'd2, 2'b01, 32'hA1, 32'hA2);
    push(5'd3, 5'd4, 2'b10, 32'hB1, 32'hB2);
    push(5'd5, 5'd6, 2'b00, 32'hC1, 32'hC2);
    push(5'd7, 5'd8, 2'b11, 32'hD1, 32'hD2);
    repeat (8) cyc();
    exp_a = '{5'd1, 5'd4, 5'd7, 5'd8};
    chk("mask_nwrites", obs_a.size(), 4);
    for (int i = 0; i < 4 && i < obs_a.size(); i++) chk("mask_order", obs_a[i], exp_a[i]);

    // back-pressure and full boundary
    wr_stall = 1;
    in_valid = 1; in_wmask = 2'b11; in_rd1 = 5'd9;  in_rd2 = 5'd10; in_y1 = 32'h900; in_y2 = 32'hA00;
    cyc();
    in_rd1 = 5'd11; in_rd2 = 5'd12; in_y1 = 32'hB00; in_y2 = 32'hC00;
    cyc();
    sa = wr_addr; sd = wr_data;
    chk("bp_first_addr", sa, 9);
    repeat (3) cyc();
    in_rd1 = 5'd13; in_rd2 = 5'd14; in_y1 = 32'hD00; in_y2 = 32'hE00;
    chk("bp_hold_addr", wr_addr, sa); chk("bp_hold_data", wr_data, sd);
    chk("bp_full_count", count, 2); chk("bp_full_ready", in_ready, 0);
    wr_stall = 0;
    cyc();
    chk("full_no_accept", count, 1); chk("full_y2_addr", wr_addr, 10);
    cyc();
    chk("full_accept_next", count, 2);
    in_valid = 0;
    repeat (12) cyc();
    chk("bp_drained", busy, 0);

`ifdef ALU_WB_BYPASS_EN
    wr_stall = 1; q_addr = 5'd7;
    push(5'd7, 5'd7, 2'b11, 32'd5, 32'd9);
    chk("byp_hit_q", q_hit, 1); chk("byp_data_q", q_data, 9);
    cyc();
    chk("byp_hit_ph1", q_hit, 1); chk("byp_data_ph1", q_data, 9);
    q_addr = 5'd0; #1;
    chk("byp_zero", q_hit, 0);
    q_addr = 5'd7; wr_stall = 0;
    cyc();
    chk("byp_hit_y2", q_hit, 1); chk("byp_data_y2", q_data, 9);
    cyc();
    chk("byp_gone", q_hit, 0);
    repeat (3) cyc();
`endif

    // reset mid-stream with two pairs queued and a pending write
    wr_stall = 1;
    push(5'd15, 5'd16, 2'b11, 32'h15, 32'h16);
    push(5'd17, 5'd18, 2'b11, 32'h17, 32'h18);
    chk("pre_rst_en", wr_en, 1); chk("pre_rst_count", count, 2);
    #2 rst_n = 0;
    #1;
    chk("midrst_wr_en", wr_en, 0); chk("midrst_count", count, 0);
    chk("midrst_ready", in_ready, 1); chk("midrst_busy", busy, 0);
    wr_stall = 0;
    cyc(); cyc();
    rst_n = 1;
    obs_a.delete();
    repeat (6) cyc();
    chk("post_rst_writes", obs_a.size(), 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(3) != 0);
      wr_stall = ($urandom_range(2) == 0);
      in_wmask = 2'($urandom_range(3));
      in_rd1   = 5'($urandom_range(7));
      in_rd2   = 5'($urandom_range(7));
      in_y1    = $urandom;
      in_y2    = $urandom;
`ifdef ALU_WB_BYPASS_EN
      q_addr   = 5'($urandom_range(7));
`endif
      cyc();
    end
    in_valid = 0; wr_stall = 0;
    repeat (10) cyc();
    chk("final_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Writeback stage directly downstream of the ALU.
- Captures each ALU result pair (Y1, Y2) with its destination register addresses and per-result write mask into a small FIFO.
- Serialises the pair onto the register file's single write port, one 32-bit write per cycle, with back-pressure in both directions.

Parameters:
WIDTH, 32, data width of each result word
AW, 5, register address width
DEPTH, 2, FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ALU result pair present
in_ready  out  1  stage can accept a pair this cycle
in_y1  in  WIDTH  ALU Y1 result
in_y2  in  WIDTH  ALU Y2 result
in_rd1  in  AW  destination register for Y1
in_rd2  in  AW  destination register for Y2
in_wmask  in  2  bit0 = write Y1, bit1 = write Y2
wr_stall  in  1  register file cannot take a write this cycle
wr_en  out  1  write pending on the port
wr_addr  out  AW  write address
wr_data  out  WIDTH  write data
busy  out  1  FIFO non-empty or wr_en high
count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - Reset is asynchronous and active-low on rst_n.
  - On reset: FIFO empty, count=0, phase=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, in_ready=1.
  - Reset mid-operation discards all queued and pending writes; no partial write may follow release.
- Input handshake:
  - A pair is accepted on a rising edge where in_valid && in_ready.
  - in_ready = (count < DEPTH), from registered state only.
  - A full FIFO does not accept in the same cycle it pops.
- Output handshake:
  - The output register holds one write.
  - The write retires on a rising edge where wr_en && !wr_stall.
  - While wr_stall=1, wr_en/wr_addr/wr_data hold stable.
- Load: the output register loads from the FIFO head when it is empty or retiring this cycle. Sequencer phase bit (0=Y1 slot, 1=Y2 slot) per head mask:
  - 11, phase 0: load (rd1, y1); phase 0->1; no pop.
  - 11, phase 1: load (rd2, y2); pop; phase 1->0.
  - 01: load (rd1, y1); pop.
  - 10: load (rd2, y2); pop.
  - 00: pop without load; consumes one load slot; wr_en drops to 0 if nothing else loads.
- Output register when not loading: if the write retired, wr_en=0 and addr/data retain their last values.
- Ordering:
  - Writes appear in acceptance order.
  - Y1 always precedes Y2 of the same pair.
  - With rd1==rd2 and mask 11, both writes issue; Y2 is last.
- Latency: pair accepted at edge N -> first wr_en=1 visible after edge N+1 (stall-free).
- Throughput: one write per cycle sustained.
- Simultaneous push and pop (count<DEPTH): count unchanged.
- Pointers wrap modulo DEPTH.
- busy = (count!=0) || wr_en.

Optional Feature:
- Macro: ALU_WB_BYPASS_EN.
- When defined, adds three ports:
  - q_addr  in  AW
  - q_hit  out  1
  - q_data  out  WIDTH
- q_hit/q_data are combinational. They search every not-yet-retired write (output register, then FIFO entries oldest to youngest, honouring mask and phase). The youngest match wins, so Y2 beats Y1 within a pair.
- Address 0 never hits.
- When undefined, these ports and the compare logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 mid-stream with 2 pairs queued and wr_en=1 -> outputs immediately wr_en=0, count=0, in_ready=1; no writes after release.
- Single pair: y1=0x11111111, y2=0x22222222, rd1=3, rd2=4, mask=11, no stall -> wr_en high 2 consecutive cycles, (3, 0x11111111) then (4, 0x22222222); first write one edge after acceptance.
- Mask coverage: pairs with masks 01, 10, 00, 11 back-to-back -> writes rd1 of pair0, rd2 of pair1, nothing for pair2, then rd1, rd2 of pair3; order preserved.
- Back-pressure: wr_stall=1 for 5 cycles with in_valid held -> wr_* stable; FIFO fills; in_ready=0 at count=2; release -> all writes drain in order, none lost or duplicated.
- Full boundary: count=2, in_valid=1 and a retire that pops this cycle -> input not accepted that cycle; accepted the next cycle.
- Bypass (ALU_WB_BYPASS_EN): queue rd1=rd2=7, mask 11, y1=5, y2=9, q_addr=7 -> q_hit=1, q_data=9 until the Y2 write retires, then q_hit=0; q_addr=0 -> q_hit=0 always.
